// File: rtl/uart_matrix_engine.sv
// uart_matrix_engine: byte-stream matrix add/multiply engine (opcode, A, B in; status + C out).
// Define UART_MATRIX_CHECKSUM_EN to require a request XOR checksum byte and append an XOR trailer to responses.
module uart_matrix_engine #(
    parameter int DIM         = 2,
    parameter int EBYTES      = 4,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,
    output logic       busy,
    output logic       err_timeout
);
    localparam int RBYTES = 2 * EBYTES;
    localparam int EW     = 8 * EBYTES;
    localparam int RW     = 8 * RBYTES;
    localparam int NE     = DIM * DIM;
    localparam int IW     = (NE > 1) ? $clog2(NE) : 1;
    localparam int ECW    = IW + 1;
    localparam int CW     = $clog2(DIM + 1);
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, RECV_A, RECV_B, COMPUTE, SEND} state_t;
    state_t state, state_nxt;

    logic [EW-1:0]  mat_a [2**IW];
    logic [EW-1:0]  mat_b [2**IW];
    logic [RW-1:0]  mat_c [2**IW];
    logic [RW-1:0]  acc, mac;
    logic [ECW-1:0] ecnt;
    logic [2:0]     bcnt, blim;
    logic [CW-1:0]  ci, cj, ck;
    logic [TW-1:0]  tcnt;
    logic [IW-1:0]  a_idx, b_idx, c_idx;
    logic [7:0]     resp_code, data_byte;
    logic           op_mul, hdr_sent;
    logic           in_recv, rx_byte, rx_last, timeout, fire, payload_last, send_done;
    logic           k_last, comp_last, step;
`ifdef UART_MATRIX_CHECKSUM_EN
    logic [7:0]     rx_ck, tx_ck;
    logic           tail, ck_byte, ck_ok;
`endif

    always_comb begin
        in_recv      = state == RECV_A || state == RECV_B;
        rx_byte      = in_recv && rx_data_valid && ecnt != ECW'(NE);
        rx_last      = rx_byte && ecnt == ECW'(NE - 1) && bcnt == 3'(EBYTES - 1);
        timeout      = in_recv && !rx_data_valid && tcnt == TW'(TIMEOUT_CYC - 1);
        fire         = state == SEND && tx_data_ready;
        payload_last = hdr_sent ? (ecnt == ECW'(NE - 1) && bcnt == 3'(RBYTES - 1)) : resp_code != 8'hA5;
        k_last       = !op_mul || ck == CW'(DIM - 1);
        comp_last    = state == COMPUTE && k_last && ci == CW'(DIM - 1) && cj == CW'(DIM - 1);
        blim         = state == SEND ? 3'(RBYTES - 1) : 3'(EBYTES - 1);
        a_idx        = IW'(ci * DIM + ck);
        b_idx        = IW'(ck * DIM + cj);
        c_idx        = IW'(ci * DIM + cj);
        mac          = (ck == '0 ? RW'(0) : acc) + RW'(mat_a[a_idx]) * RW'(mat_b[b_idx]);
`ifdef UART_MATRIX_CHECKSUM_EN
        ck_byte      = state == RECV_B && rx_data_valid && ecnt == ECW'(NE);
        ck_ok        = rx_data == rx_ck;
        step         = rx_byte || (fire && hdr_sent && !tail);
        send_done    = fire && tail;
`else
        step         = rx_byte || (fire && hdr_sent);
        send_done    = fire && payload_last;
`endif
    end

    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_data_valid) state_nxt = (rx_data == 8'h01 || rx_data == 8'h02) ? RECV_A : SEND;
            RECV_A:  state_nxt = timeout ? IDLE : rx_last ? RECV_B : RECV_A;
`ifdef UART_MATRIX_CHECKSUM_EN
            RECV_B:  state_nxt = timeout ? IDLE : ck_byte ? (ck_ok ? COMPUTE : SEND) : RECV_B;
`else
            RECV_B:  state_nxt = timeout ? IDLE : rx_last ? COMPUTE : RECV_B;
`endif
            COMPUTE: state_nxt = comp_last ? SEND : COMPUTE;
            SEND:    state_nxt = send_done ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    // tx_data only depends on registers that move on acceptance, so it holds under backpressure
    always_comb begin
        busy          = state != IDLE;
        tx_data_valid = state == SEND;
        data_byte     = mat_c[ecnt[IW-1:0]][8*(RBYTES-1-int'(bcnt)) +: 8];
`ifdef UART_MATRIX_CHECKSUM_EN
        tx_data       = state != SEND ? 8'h00 : tail ? tx_ck : !hdr_sent ? resp_code : data_byte;
`else
        tx_data       = state != SEND ? 8'h00 : !hdr_sent ? resp_code : data_byte;
`endif
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt        <= '0;
            bcnt        <= '0;
            ci          <= '0;
            cj          <= '0;
            ck          <= '0;
            tcnt        <= '0;
            op_mul      <= 1'b0;
            hdr_sent    <= 1'b0;
            resp_code   <= 8'h00;
            err_timeout <= 1'b0;
`ifdef UART_MATRIX_CHECKSUM_EN
            rx_ck       <= 8'h00;
            tx_ck       <= 8'h00;
            tail        <= 1'b0;
`endif
        end else begin
            err_timeout <= timeout;
            tcnt        <= (in_recv && state_nxt == state && !rx_data_valid) ? tcnt + 1'b1 : '0;
            // every state entry starts its counters from zero
            if (state_nxt != state) begin
                ecnt     <= '0;
                bcnt     <= '0;
                ci       <= '0;
                cj       <= '0;
                ck       <= '0;
                hdr_sent <= 1'b0;
            end else begin
                if (step) begin
                    bcnt <= bcnt == blim ? '0 : bcnt + 1'b1;
                    ecnt <= ecnt + ECW'(bcnt == blim);
                end
                if (fire) hdr_sent <= 1'b1;
                if (state == COMPUTE) begin
                    ck <= k_last ? '0 : ck + 1'b1;
                    if (k_last) begin
                        cj <= cj == CW'(DIM - 1) ? '0 : cj + 1'b1;
                        ci <= ci + CW'(cj == CW'(DIM - 1));
                    end
                end
            end
            if (state == IDLE && rx_data_valid) begin
                op_mul    <= rx_data == 8'h02;
                resp_code <= (rx_data == 8'h01 || rx_data == 8'h02) ? 8'hA5 : 8'hEE;
            end
`ifdef UART_MATRIX_CHECKSUM_EN
            if (ck_byte && !ck_ok) resp_code <= 8'hE5;
            if (state == IDLE && rx_data_valid) rx_ck <= rx_data;
            else if (rx_byte)                   rx_ck <= rx_ck ^ rx_data;
            tx_ck <= state_nxt != state ? 8'h00 : fire ? tx_ck ^ tx_data : tx_ck;
            tail  <= state_nxt != state ? 1'b0 : (fire && payload_last) ? 1'b1 : tail;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rx_byte && state == RECV_A) mat_a[ecnt[IW-1:0]][8*(EBYTES-1-int'(bcnt)) +: 8] <= rx_data;
        if (rx_byte && state == RECV_B) mat_b[ecnt[IW-1:0]][8*(EBYTES-1-int'(bcnt)) +: 8] <= rx_data;
        if (state == COMPUTE) begin
            acc <= mac;
            if (k_last) mat_c[c_idx] <= op_mul ? mac : RW'(mat_a[c_idx]) + RW'(mat_b[c_idx]);
        end
    end
endmodule

// File: tb/tb_uart_matrix_engine.sv
// tb_uart_matrix_engine: directed tests for uart_matrix_engine (DIM=2, EBYTES=4, short timeout).
module tb_uart_matrix_engine;
    localparam int TO = 200;

    typedef logic [31:0] mat_t [4];
    typedef logic [63:0] res_t [4];

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_ready = 1'b1;
    logic       busy;
    logic       err_timeout;

    int vectors = 0;
    int miscompares = 0;
    int to_pulses = 0;

    uart_matrix_engine #(.DIM(2), .EBYTES(4), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) if (err_timeout) to_pulses++;

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_data_valid = 1'b1;
        @(negedge sys_clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input mat_t a, input mat_t b, input int gap_at, input int gap);
        logic [7:0] q [$];
        q.push_back(op);
        for (int i = 0; i < 4; i++) for (int j = 3; j >= 0; j--) q.push_back(a[i][8*j +: 8]);
        for (int i = 0; i < 4; i++) for (int j = 3; j >= 0; j--) q.push_back(b[i][8*j +: 8]);
`ifdef UART_MATRIX_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            foreach (q[k]) x ^= q[k];
            q.push_back(x);
        end
`endif
        foreach (q[k]) begin
            if (k == gap_at) repeat (gap) @(negedge sys_clk);
            send_byte(q[k]);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        while (tx_data_valid !== 1'b1 && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        if (tx_data_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_wait: tx_data_valid=%b after %0d cycles, required 1", tx_data_valid, n);
            b = 8'h00;
        end else begin
            b = tx_data;
            @(negedge sys_clk);
        end
    endtask

    task automatic get_result(output logic [7:0] st, output res_t c);
        logic [7:0] b;
        recv_byte(st);
        for (int i = 0; i < 4; i++) begin
            c[i] = '0;
            for (int j = 0; j < 8; j++) begin
                recv_byte(b);
                c[i] = {c[i][55:0], b};
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        vectors += 4;
        if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        if (tx_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid: got %b, required 0", tx_data_valid); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_err_timeout: got %b, required 0", err_timeout); end
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_multiply;
        logic [7:0] st;
        res_t c;
        res_t e;
        e = '{64'd19, 64'd22, 64'd43, 64'd50};
        send_frame(8'h02, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        vectors++;
        if (st !== 8'hA5) begin miscompares++; $display("FAIL mul_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL mul_c%0d: got %0d, required %0d", i, c[i], e[i]); end
        end
`ifdef UART_MATRIX_CHECKSUM_EN
        repeat (2) @(negedge sys_clk);
`endif
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mul_busy_after: got %b, required 0", busy); end
    endtask

    task automatic test_add;
        logic [7:0] st;
        res_t c;
        res_t e;
        e = '{64'd6, 64'd8, 64'd10, 64'd12};
        send_frame(8'h01, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        vectors++;
        if (st !== 8'hA5) begin miscompares++; $display("FAIL add_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL add_c%0d: got %h, required %h", i, c[i], e[i]); end
        end
        @(negedge sys_clk);
        e = '{64'h1_FFFF_FFFE, 64'd8, 64'd10, 64'd12};
        send_frame(8'h01, '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'd4}, '{32'hFFFF_FFFF, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL add_carry_c%0d: got %h, required %h", i, c[i], e[i]); end
        end
        @(negedge sys_clk);
    endtask

    task automatic test_bad_opcode;
        logic [7:0] b;
        logic [7:0] st;
        res_t c;
        res_t e;
        e = '{64'd19, 64'd22, 64'd43, 64'd50};
        send_byte(8'h7F);
        recv_byte(b);
        vectors++;
        if (b !== 8'hEE) begin miscompares++; $display("FAIL badop_resp: got %h, required ee", b); end
`ifdef UART_MATRIX_CHECKSUM_EN
        recv_byte(b);
        vectors++;
        if (b !== 8'hEE) begin miscompares++; $display("FAIL badop_trailer: got %h, required ee", b); end
`endif
        @(negedge sys_clk);
        vectors++;
        if (busy !== 1'b0 || tx_data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL badop_idle: busy=%b valid=%b, required 0 0", busy, tx_data_valid);
        end
        send_frame(8'h02, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        vectors++;
        if (st !== 8'hA5) begin miscompares++; $display("FAIL badop_next_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL badop_next_c%0d: got %0d, required %0d", i, c[i], e[i]); end
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_timeout;
        int n = 0;
        logic [7:0] st;
        res_t c;
        res_t e;
        e = '{64'd6, 64'd8, 64'd10, 64'd12};
        send_byte(8'h02);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        while (err_timeout !== 1'b1 && n < TO + 50) begin
            @(negedge sys_clk);
            n++;
        end
        vectors += 2;
        if (n != TO) begin miscompares++; $display("FAIL timeout_latency: pulse after %0d cycles, required %0d", n, TO); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL timeout_busy: got %b, required 0", busy); end
        @(negedge sys_clk);
        vectors++;
        if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse_width: got %b, required 0", err_timeout); end
        send_frame(8'h01, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        vectors++;
        if (st !== 8'hA5) begin miscompares++; $display("FAIL timeout_next_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL timeout_next_c%0d: got %0d, required %0d", i, c[i], e[i]); end
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_timeout_edge;
        int p0;
        logic [7:0] st;
        res_t c;
        res_t e;
        e = '{64'hFFFF_FFFE_0000_0004, 64'd4, 64'd6, 64'd8};
        p0 = to_pulses;
        send_frame(8'h02, '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd2}, '{32'hFFFF_FFFF, 32'd0, 32'd3, 32'd4}, 6, TO - 1);
        get_result(st, c);
        vectors += 2;
        if (to_pulses != p0) begin miscompares++; $display("FAIL edge_no_timeout: %0d pulses, required 0", to_pulses - p0); end
        if (st !== 8'hA5) begin miscompares++; $display("FAIL edge_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL edge_c%0d: got %h, required %h", i, c[i], e[i]); end
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_backpressure;
        logic [7:0] b, hold, st;
        logic stable;
        res_t c;
        res_t e;
        e = '{64'hFFFF_FFFC_0000_0002, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd1};
        send_frame(8'h02, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0}, '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0}, 0, 0);
        recv_byte(st);
        for (int i = 0; i < 4; i++) begin
            c[i] = '0;
            for (int j = 0; j < 8; j++) begin
                if (i == 0 && j == 4) begin
                    tx_data_ready = 1'b0;
                    hold = tx_data;
                    stable = 1'b1;
                    for (int k = 0; k < 50; k++) begin
                        if (k == 10 || k == 20) send_byte(8'h02);
                        else @(negedge sys_clk);
                        if (tx_data !== hold || tx_data_valid !== 1'b1) stable = 1'b0;
                    end
                    vectors++;
                    if (stable !== 1'b1) begin miscompares++; $display("FAIL bp_stable: data %h valid %b, required %h 1", tx_data, tx_data_valid, hold); end
                    tx_data_ready = 1'b1;
                end
                recv_byte(b);
                c[i] = {c[i][55:0], b};
            end
        end
        vectors++;
        if (st !== 8'hA5) begin miscompares++; $display("FAIL bp_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL bp_c%0d: got %h, required %h", i, c[i], e[i]); end
        end
`ifdef UART_MATRIX_CHECKSUM_EN
        recv_byte(b);
`endif
        repeat (2) @(negedge sys_clk);
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_rx_ignored: busy=%b, required 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b, st;
        logic quiet;
        res_t c;
        res_t e;
        e = '{64'd6, 64'd8, 64'd10, 64'd12};
        send_frame(8'h02, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        for (int i = 0; i < 3; i++) recv_byte(b);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || tx_data_valid !== 1'b0 || tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_abort: busy=%b valid=%b data=%h, required 0 0 00", busy, tx_data_valid, tx_data);
        end
        @(negedge sys_clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge sys_clk);
            if (tx_data_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        vectors++;
        if (quiet !== 1'b1) begin miscompares++; $display("FAIL midreset_quiet: spurious activity, required none"); end
        send_frame(8'h01, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        vectors++;
        if (st !== 8'hA5) begin miscompares++; $display("FAIL midreset_status: got %h, required a5", st); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (c[i] !== e[i]) begin miscompares++; $display("FAIL midreset_c%0d: got %0d, required %0d", i, c[i], e[i]); end
        end
        repeat (3) @(negedge sys_clk);
    endtask

`ifdef UART_MATRIX_CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] x, b, st;
        res_t c;
        x = 8'h01;
        send_byte(8'h01);
        for (int k = 0; k < 32; k++) begin
            send_byte(8'(k * 7));
            x ^= 8'(k * 7);
        end
        send_byte(x ^ 8'h5A);
        recv_byte(b);
        vectors++;
        if (b !== 8'hE5) begin miscompares++; $display("FAIL ck_bad_resp: got %h, required e5", b); end
        recv_byte(b);
        vectors++;
        if (b !== 8'hE5) begin miscompares++; $display("FAIL ck_bad_trailer: got %h, required e5", b); end
        @(negedge sys_clk);
        send_frame(8'h01, '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8}, 0, 0);
        get_result(st, c);
        recv_byte(b);
        x = 8'hA5 ^ 8'd6 ^ 8'd8 ^ 8'd10 ^ 8'd12;
        vectors += 2;
        if (c[3] !== 64'd12) begin miscompares++; $display("FAIL ck_good_c3: got %0d, required 12", c[3]); end
        if (b !== x) begin miscompares++; $display("FAIL ck_good_trailer: got %h, required %h", b, x); end
        repeat (3) @(negedge sys_clk);
    endtask
`endif

    initial begin
        test_reset;
        test_multiply;
        test_add;
        test_bad_opcode;
        test_timeout;
        test_timeout_edge;
        test_backpressure;
        test_reset_mid;
`ifdef UART_MATRIX_CHECKSUM_EN
        test_checksum;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_matrix_engine.md
UART_MATRIX_ENGINE -- requirements
Module: uart_matrix_engine

Interface
REQ-001 SHALL use reset rst_n, asynchronous, active-low; clock sys_clk.
REQ-002 SHALL have parameter DIM, default 2, matrix dimension (legal 1..8).
REQ-003 SHALL have parameter EBYTES, default 4, bytes per input element (legal 1..4); result element is RBYTES = 2*EBYTES bytes.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2000000, inter-byte receive timeout in sys_clk cycles.
REQ-005 SHALL have ports: sys_clk in 1 clock; rst_n in 1 reset; rx_data in 8 received byte; rx_data_valid in 1 one-cycle byte strobe; tx_data out 8 byte to transmit; tx_data_valid out 1 transmit request; tx_data_ready in 1 transmitter accepts byte; busy out 1 high outside IDLE; err_timeout out 1 one-cycle timeout pulse.

Function
REQ-006 SHALL implement states IDLE, RECV_A, RECV_B, COMPUTE, SEND.
REQ-007 IDLE: a received byte SHALL be the opcode; 0x01 = add, 0x02 = multiply -> RECV_A; any other opcode -> SEND with a one-byte response 0xEE.
REQ-008 RECV_A/RECV_B SHALL each take DIM*DIM*EBYTES bytes, row-major, big-endian per element; after the last B byte -> COMPUTE.
REQ-009 A byte counter SHALL reset on every state entry; no byte is lost or duplicated at the A/B boundary.
REQ-010 Add: C[i][j] = A[i][j] + B[i][j], unsigned, zero-extended to RBYTES*8 bits, one element per cycle (DIM*DIM cycles).
REQ-011 Multiply: C[i][j] = sum over k of A[i][k]*B[k][j], unsigned, truncated modulo 2^(RBYTES*8), one MAC per cycle (DIM*DIM*DIM cycles), a single shared multiplier.
REQ-012 COMPUTE -> SEND on the cycle after the last element is written.
REQ-013 SEND SHALL emit status byte 0xA5, then DIM*DIM result elements row-major, RBYTES bytes each, big-endian, then -> IDLE.
REQ-014 A tx byte is transferred when tx_data_valid and tx_data_ready are both high on a rising edge; tx_data SHALL be stable while tx_data_valid is high and unaccepted.
REQ-015 rx_data_valid during COMPUTE or SEND SHALL be ignored (byte discarded).
REQ-016 In RECV_A/RECV_B, TIMEOUT_CYC cycles without rx_data_valid SHALL pulse err_timeout for one cycle and return to IDLE, discarding partial data; the counter clears on each received byte.
REQ-017 rx_data_valid on the same cycle as the timeout expiry SHALL be accepted and the timeout suppressed.
REQ-018 busy SHALL be low only in IDLE.

Reset
REQ-019 On rst_n low, SHALL enter IDLE: tx_data = 0x00, tx_data_valid = 0, busy = 0, err_timeout = 0, all counters 0.
REQ-020 Reset mid-transfer SHALL abort immediately; matrix storage contents need not be cleared.
REQ-021 Reset release SHALL take effect on the first sys_clk rising edge after deassertion; no byte is emitted spuriously.

Configuration
REQ-022 With macro UART_MATRIX_CHECKSUM_EN defined: after the last B byte, one extra received byte SHALL equal the XOR of the opcode and all A/B bytes. On mismatch, respond 0xE5 only and -> IDLE. Each response SHALL append a trailing byte equal to the XOR of all preceding response bytes.
REQ-023 Without UART_MATRIX_CHECKSUM_EN, no checksum byte SHALL be expected or sent; frame lengths are per REQ-008/REQ-013.

Verification (DIM=2, EBYTES=4)
REQ-024 Opcode 0x02, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> 0xA5 then 8-byte elements 19, 22, 43, 50.
REQ-025 Opcode 0x01, same A/B -> 0xA5 then 6, 8, 10, 12; A[0][0]=B[0][0]=0xFFFFFFFF -> C[0][0]=0x1_FFFFFFFE.
REQ-026 Opcode 0x7F -> single byte 0xEE, busy low afterwards, next valid frame processed correctly.
REQ-027 Send opcode + 10 bytes, then idle TIMEOUT_CYC cycles -> err_timeout pulse, busy low, following full frame correct.
REQ-028 tx_data_ready held low 50 cycles mid-response -> tx_data/tx_data_valid stable, no byte lost; extra rx bytes during SEND ignored.
REQ-029 With UART_MATRIX_CHECKSUM_EN, corrupt checksum -> 0xE5 plus checksum byte 0xE5; correct checksum -> normal response plus correct XOR trailer.
